// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: turns 68k-style CPU bus cycles into single memory requests with dtack/vpa handshake and timeout.
// Ports: clock/reset (sync, active-high); cpu_as/rw/uds/lds/fc/addr/dout in, cpu_din/dtack/vpa out;
//        mem_rd/wr/addr/mask/wdata out, mem_rdata/ack in; iack_valid/iack_level and timeout status out.
module cpu_bus_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_as,
  input  logic        cpu_rw,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic [2:0]  cpu_fc,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_dtack,
  output logic        cpu_vpa,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_mask,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        iack_valid,
  output logic [2:0]  iack_level,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, MEM, ACK, WAIT} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state, state_next;
  logic rw_q, iack_q, aborted;
  logic [15:0] cnt;
  logic start_iack, start_mem, expired, done;
  assign start_iack = state == IDLE && cpu_as && cpu_fc == 3'b111;
  assign start_mem  = state == IDLE && cpu_as && cpu_fc != 3'b111 && (cpu_uds | cpu_lds);
  // mem_ack has priority over an expiring counter
  assign expired    = state == MEM && !mem_ack && cnt == LAST;
  assign done       = state == MEM && (mem_ack || cnt == LAST);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_next;
  // a CPU that dropped AS during the request gets no dtack; we only wait for AS to stay low
  always_comb
    state_next = start_iack ? ACK :
                 start_mem ? MEM :
                 done ? ((aborted || !cpu_as) ? WAIT : ACK) :
                 ((state == ACK || state == WAIT) && !cpu_as) ? IDLE : state;
  always_comb begin
    mem_rd    = state == MEM && rw_q;
    mem_wr    = state == MEM && !rw_q;
    cpu_dtack = state == ACK && !iack_q;
    cpu_vpa   = state == ACK && iack_q;
  end
  always_ff @(posedge clock)
    if (reset) begin
      rw_q       <= 1'b0;
      iack_q     <= 1'b0;
      aborted    <= 1'b0;
      cnt        <= '0;
      cpu_din    <= '0;
      mem_addr   <= '0;
      mem_mask   <= '0;
      mem_wdata  <= '0;
      iack_level <= '0;
      iack_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      iack_valid <= start_iack;
      timeout    <= expired;
      if (start_iack) begin
        iack_q     <= 1'b1;
        iack_level <= cpu_addr[2:0];
      end
      if (start_mem) begin
        iack_q    <= 1'b0;
        rw_q      <= cpu_rw;
        aborted   <= 1'b0;
        cnt       <= '0;
        mem_addr  <= cpu_addr;
        mem_mask  <= {cpu_uds, cpu_lds};
        mem_wdata <= cpu_dout;
      end
      if (state == MEM) begin
        cnt <= cnt + 16'd1;
        if (!cpu_as) aborted <= 1'b1;
        if (done && rw_q) cpu_din <= mem_ack ? mem_rdata : 16'hFFFF;
      end
    end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed checks of the CPU bus responder with TIMEOUT=8.
module tb_cpu_bus_responder;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_as = 0, cpu_rw = 0, cpu_uds = 0, cpu_lds = 0, mem_ack = 0;
  logic [2:0] cpu_fc = 0;
  logic [22:0] cpu_addr = 0;
  logic [15:0] cpu_dout = 0, mem_rdata = 0;
  logic [15:0] cpu_din, mem_wdata;
  logic cpu_dtack, cpu_vpa, mem_rd, mem_wr, iack_valid, timeout;
  logic [22:0] mem_addr;
  logic [1:0] mem_mask;
  logic [2:0] iack_level;
  int n_cmp = 0, n_bad = 0;
  cpu_bus_responder #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .cpu_as(cpu_as), .cpu_rw(cpu_rw), .cpu_uds(cpu_uds),
    .cpu_lds(cpu_lds), .cpu_fc(cpu_fc), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_dtack(cpu_dtack), .cpu_vpa(cpu_vpa), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .iack_valid(iack_valid),
    .iack_level(iack_level), .timeout(timeout));
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
  task tick;
    @(posedge clock);
    #1;
  endtask
  task start_read(input logic [22:0] a);
    cpu_as = 1; cpu_rw = 1; cpu_uds = 1; cpu_lds = 1; cpu_fc = 3'd5; cpu_addr = a;
    tick;
  endtask
  task end_cycle;
    cpu_as = 0; cpu_uds = 0; cpu_lds = 0; mem_ack = 0;
    tick;
    tick;
  endtask
  task test_reset;
    reset = 1;
    tick;
    tick;
    reset = 0;
    n_cmp++; if ({cpu_dtack, cpu_vpa, mem_rd, mem_wr, iack_valid, timeout} !== 6'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 000000", {cpu_dtack, cpu_vpa, mem_rd, mem_wr, iack_valid, timeout}); end
    n_cmp++; if ({cpu_din, mem_addr, mem_mask, mem_wdata, iack_level} !== 60'b0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {cpu_din, mem_addr, mem_mask, mem_wdata, iack_level}); end
  endtask
  task test_read;
    start_read(23'h001234);
    n_cmp++; if ({mem_rd, mem_wr, cpu_dtack} !== 3'b100) begin n_bad++; $display("FAIL read_req: got %b want 100", {mem_rd, mem_wr, cpu_dtack}); end
    n_cmp++; if (mem_addr !== 23'h001234) begin n_bad++; $display("FAIL read_addr: got %h want 001234", mem_addr); end
    n_cmp++; if (mem_mask !== 2'b11) begin n_bad++; $display("FAIL read_mask: got %b want 11", mem_mask); end
    tick;
    tick;
    mem_ack = 1; mem_rdata = 16'hBEEF;
    n_cmp++; if ({mem_rd, cpu_dtack} !== 2'b10) begin n_bad++; $display("FAIL read_hold: got %b want 10", {mem_rd, cpu_dtack}); end
    tick;
    mem_ack = 0; mem_rdata = 16'h0000;
    n_cmp++; if ({cpu_dtack, mem_rd} !== 2'b10) begin n_bad++; $display("FAIL read_dtack: got %b want 10", {cpu_dtack, mem_rd}); end
    n_cmp++; if (cpu_din !== 16'hBEEF) begin n_bad++; $display("FAIL read_din: got %h want beef", cpu_din); end
    tick;
    cpu_as = 0;
    n_cmp++; if ({cpu_dtack, cpu_din} !== {1'b1, 16'hBEEF}) begin n_bad++; $display("FAIL read_dtack_hold: got %h want 1beef", {cpu_dtack, cpu_din}); end
    tick;
    n_cmp++; if (cpu_dtack !== 1'b0) begin n_bad++; $display("FAIL read_dtack_drop: got %b want 0", cpu_dtack); end
    end_cycle;
  endtask
  task test_late_strobe;
    cpu_as = 1; cpu_rw = 0; cpu_fc = 3'd5; cpu_addr = 23'h000055; cpu_dout = 16'h00A5;
    tick;
    n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("FAIL late_nostrobe: got %b want 00", {mem_rd, mem_wr}); end
    cpu_lds = 1;
    tick;
    n_cmp++; if ({mem_rd, mem_wr, mem_mask} !== 4'b0101) begin n_bad++; $display("FAIL late_req: got %b want 0101", {mem_rd, mem_wr, mem_mask}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {23'h000055, 16'h00A5}) begin n_bad++; $display("FAIL late_data: got %h want 5500a5", {mem_addr, mem_wdata}); end
    mem_ack = 1;
    tick;
    mem_ack = 0;
    n_cmp++; if ({cpu_dtack, mem_wr} !== 2'b10) begin n_bad++; $display("FAIL late_dtack: got %b want 10", {cpu_dtack, mem_wr}); end
    end_cycle;
    n_cmp++; if (cpu_dtack !== 1'b0) begin n_bad++; $display("FAIL late_end: got %b want 0", cpu_dtack); end
  endtask
  task test_iack;
    cpu_as = 1; cpu_rw = 1; cpu_fc = 3'd7; cpu_addr = 23'h7FFFFC;
    tick;
    n_cmp++; if ({iack_valid, cpu_vpa, cpu_dtack, iack_level} !== 6'b110100) begin n_bad++; $display("FAIL iack_start: got %b want 110100", {iack_valid, cpu_vpa, cpu_dtack, iack_level}); end
    n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("FAIL iack_nomem: got %b want 00", {mem_rd, mem_wr}); end
    tick;
    cpu_as = 0;
    n_cmp++; if ({iack_valid, cpu_vpa} !== 2'b01) begin n_bad++; $display("FAIL iack_hold: got %b want 01", {iack_valid, cpu_vpa}); end
    tick;
    n_cmp++; if ({cpu_vpa, iack_level} !== 4'b0100) begin n_bad++; $display("FAIL iack_end: got %b want 0100", {cpu_vpa, iack_level}); end
    cpu_fc = 3'd5;
    end_cycle;
  endtask
  task test_timeout;
    start_read(23'h000100);
    for (int i = 0; i < 7; i++) begin
      tick;
      n_cmp++; if ({mem_rd, timeout, cpu_dtack} !== 3'b100) begin n_bad++; $display("FAIL to_wait%0d: got %b want 100", i, {mem_rd, timeout, cpu_dtack}); end
    end
    tick;
    n_cmp++; if ({timeout, cpu_dtack, mem_rd} !== 3'b110) begin n_bad++; $display("FAIL to_pulse: got %b want 110", {timeout, cpu_dtack, mem_rd}); end
    n_cmp++; if (cpu_din !== 16'hFFFF) begin n_bad++; $display("FAIL to_din: got %h want ffff", cpu_din); end
    tick;
    n_cmp++; if ({timeout, cpu_dtack, mem_rd} !== 3'b010) begin n_bad++; $display("FAIL to_after: got %b want 010", {timeout, cpu_dtack, mem_rd}); end
    end_cycle;
  endtask
  task test_coincide;
    start_read(23'h000200);
    for (int i = 0; i < 7; i++) tick;
    mem_ack = 1; mem_rdata = 16'h1357;
    tick;
    mem_ack = 0;
    n_cmp++; if ({timeout, cpu_dtack, cpu_din} !== {2'b01, 16'h1357}) begin n_bad++; $display("FAIL coincide: got %h want 11357", {timeout, cpu_dtack, cpu_din}); end
    end_cycle;
  endtask
  task test_abort;
    start_read(23'h000300);
    cpu_as = 0;
    tick;
    n_cmp++; if ({mem_rd, cpu_dtack} !== 2'b10) begin n_bad++; $display("FAIL abort_hold: got %b want 10", {mem_rd, cpu_dtack}); end
    mem_ack = 1; mem_rdata = 16'h2468;
    tick;
    mem_ack = 0;
    n_cmp++; if ({mem_rd, cpu_dtack, cpu_din} !== {2'b00, 16'h2468}) begin n_bad++; $display("FAIL abort_done: got %h want 02468", {mem_rd, cpu_dtack, cpu_din}); end
    tick;
    n_cmp++; if (cpu_dtack !== 1'b0) begin n_bad++; $display("FAIL abort_nodtack: got %b want 0", cpu_dtack); end
    end_cycle;
  endtask
  task test_reset_mid;
    start_read(23'h000400);
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL rmid_req: got %b want 1", mem_rd); end
    reset = 1; cpu_as = 0;
    tick;
    reset = 0;
    n_cmp++; if ({mem_rd, mem_wr, cpu_dtack, cpu_vpa, mem_addr, mem_mask, cpu_din} !== 45'b0) begin n_bad++; $display("FAIL rmid_clear: got %h want 0", {mem_rd, mem_wr, cpu_dtack, cpu_vpa, mem_addr, mem_mask, cpu_din}); end
    mem_ack = 1; mem_rdata = 16'hAAAA;
    tick;
    mem_ack = 0;
    tick;
    n_cmp++; if ({cpu_dtack, mem_rd, cpu_din} !== 18'b0) begin n_bad++; $display("FAIL rmid_lateack: got %h want 0", {cpu_dtack, mem_rd, cpu_din}); end
  endtask
  initial begin
    test_reset;
    test_read;
    test_late_strobe;
    test_iack;
    test_timeout;
    test_coincide;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
